// File: rtl/random_word_assembler_pkg.sv
// Shared types and constants for the random word assembler.
// Optional feature macro: RANDOM_WORD_LFSR_MIX_EN (uses the LFSR constants below).
package random_word_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        CHECK  = 3'd4,
        VALID  = 3'd5
    } state_t;

    localparam logic [7:0] LFSR_SEED    = 8'hA5;
    // Taps for x^8+x^6+x^5+x^4+1 in a right-shifting Fibonacci register
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam int         REJECT_CNT_W = 8;

    // Feedback bit: XOR of the tapped bits, shifted in at the MSB
    function automatic logic lfsr_feedback(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/random_word_assembler_lfsr8.sv
// 8-bit Fibonacci LFSR used to whiten the sampled random bits.
// Only exists when RANDOM_WORD_LFSR_MIX_EN is defined, so the default
// build carries no LFSR logic at all.
`ifdef RANDOM_WORD_LFSR_MIX_EN
module random_lfsr8
    import random_word_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] lfsr_r;

    // Free-running shift register, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_feedback(lfsr_r), lfsr_r[7:1]};
        end
    end

    assign q = lfsr_r;

endmodule
`endif

// File: rtl/random_word_assembler.sv
// Random word assembler: pulses the 1-bit random source, collects WIDTH
// samples MSB first, rejection-samples into [MIN_VAL, MAX_VAL] and hands
// accepted words over a valid/ready interface.
// Optional feature macro: RANDOM_WORD_LFSR_MIX_EN (XOR samples with an LFSR bit).
module random_word_assembler
    import random_word_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 9,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    rand_rise,
    input  logic                    rand_bit,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [REJECT_CNT_W-1:0] reject_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [SET_W-1:0]        SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0]        MIN_W    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]        MAX_W    = WIDTH'(MAX_VAL);
    localparam logic [REJECT_CNT_W-1:0] REJ_SAT  = {REJECT_CNT_W{1'b1}};

    // Parameter sanity: refuse to elaborate an impossible configuration
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("random_word_assembler: WIDTH must be 1..16");
    end
    if (MIN_VAL < 0 || MIN_VAL > MAX_VAL) begin : g_bad_min
        $error("random_word_assembler: MIN_VAL must be 0..MAX_VAL");
    end
    if (MAX_VAL >= (1 << WIDTH)) begin : g_bad_max
        $error("random_word_assembler: MAX_VAL must fit in WIDTH bits");
    end
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("random_word_assembler: SETTLE_CYCLES must be at least 2");
    end

    state_t                    state_r;
    state_t                    state_s;
    logic [SET_W-1:0]          settle_cnt_r;
    logic [IDX_W-1:0]          idx_r;
    logic [WIDTH-1:0]          shreg_r;
    logic [WIDTH-1:0]          shift_s;
    logic                      sample_bit_s;
    logic                      ge_min_s;
    logic                      le_max_s;
    logic                      in_range_s;
    logic                      rand_rise_r;
    logic                      busy_r;
    logic                      out_valid_r;
    logic [WIDTH-1:0]          out_data_r;
    logic [REJECT_CNT_W-1:0]   reject_cnt_r;

`ifdef RANDOM_WORD_LFSR_MIX_EN
    logic [7:0] lfsr_s;

    random_lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_s)
    );

    assign sample_bit_s = rand_bit ^ lfsr_s[0];
`else
    assign sample_bit_s = rand_bit;
`endif

    // New sample enters at the LSB; a 1-bit word is just the sample
    if (WIDTH == 1) begin : g_shift_one
        assign shift_s = sample_bit_s;
    end else begin : g_shift_many
        assign shift_s = {shreg_r[WIDTH-2:0], sample_bit_s};
    end

    // Bounds that cover the whole WIDTH range are constant-true and skipped
    if (MIN_VAL == 0) begin : g_min_open
        assign ge_min_s = 1'b1;
    end else begin : g_min_cmp
        assign ge_min_s = (shreg_r >= MIN_W);
    end
    if (MAX_VAL == (1 << WIDTH) - 1) begin : g_max_open
        assign le_max_s = 1'b1;
    end else begin : g_max_cmp
        assign le_max_s = (shreg_r <= MAX_W);
    end
    assign in_range_s = ge_min_s & le_max_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (settle_cnt_r == SET_LAST) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = WAIT;
                end
            end
            SAMPLE: begin
                if (idx_r == IDX_LAST) begin
                    state_s = CHECK;
                end else begin
                    state_s = REQ;
                end
            end
            CHECK: begin
                if (in_range_s) begin
                    state_s = VALID;
                end else begin
                    state_s = REQ;
                end
            end
            VALID: begin
                if (out_valid_r && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = VALID;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: settle counter, bit index, shift register, word output and reject counter
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt_r <= {SET_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            shreg_r      <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            reject_cnt_r <= {REJECT_CNT_W{1'b0}};
        end else begin
            case (state_r)
                REQ: begin
                    settle_cnt_r <= {SET_W{1'b0}};
                end
                WAIT: begin
                    settle_cnt_r <= settle_cnt_r + SET_W'(1);
                end
                SAMPLE: begin
                    shreg_r <= shift_s;
                    if (idx_r != IDX_LAST) begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                CHECK: begin
                    idx_r <= {IDX_W{1'b0}};
                    if (in_range_s) begin
                        out_data_r  <= shreg_r;
                        out_valid_r <= 1'b1;
                    end else if (reject_cnt_r != REJ_SAT) begin
                        reject_cnt_r <= reject_cnt_r + REJECT_CNT_W'(1);
                    end
                end
                VALID: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered control outputs derived from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            rand_rise_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rand_rise_r <= (state_s == REQ);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign rand_rise  = rand_rise_r;
    assign busy       = busy_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign reject_cnt = reject_cnt_r;

endmodule

// File: tb/tb_random_word_assembler.sv
// Self-checking bench for random_word_assembler (WIDTH=4, MIN=2, MAX=9, SETTLE=2).
// Raw-bit tests run in the default build; with RANDOM_WORD_LFSR_MIX_EN defined
// only the LFSR-mixing test runs.
module tb_random_word_assembler;

    localparam int W      = 4;
    localparam int SETTLE = 2;
    localparam int WORD_T = W * (SETTLE + 2) + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rand_bit = 1'b0;
    logic       out_ready = 1'b0;
    logic       rand_rise;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_data;
    logic [7:0] reject_cnt;

    random_word_assembler #(
        .WIDTH         (W),
        .MIN_VAL       (2),
        .MAX_VAL       (9),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rand_rise  (rand_rise),
        .rand_bit   (rand_bit),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        logic [3:0]  data;
        int          nrej;
        int          lat;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        int         rej;
        int         lat;
        int         rises;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rise_cnt = 0;
    int   last_rise = -100;
    int   rej_model = 0;
    int   t0;
    int   r0;
    logic bit_q[$];
    exp_t sb_q[$];
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef RANDOM_WORD_LFSR_MIX_EN
    logic [7:0] m_lfsr = 8'hA5;
    logic       cap_q[$];
    int         cap_cd = 0;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, right shift, feedback into bit 7
    always @(posedge clk) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3], m_lfsr[7:1]};
    end
`endif

    // Random source model: presents the next queued bit on every rand_rise pulse
    initial begin
        forever begin
            @(negedge clk);
`ifdef RANDOM_WORD_LFSR_MIX_EN
            if (cap_cd > 0) begin
                cap_cd--;
                if (cap_cd == 0) cap_q.push_back(rand_bit ^ m_lfsr[0]);
            end
`endif
            if (rand_rise === 1'b1) begin
                rise_cnt++;
                if (cyc - last_rise < 100) chk("rise_spacing_ok", (cyc - last_rise) >= SETTLE + 1, 1);
                last_rise = cyc;
                if (bit_q.size() > 0) rand_bit = bit_q.pop_front();
                else                  rand_bit = 1'b0;
`ifdef RANDOM_WORD_LFSR_MIX_EN
                cap_cd = SETTLE + 1;
`endif
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_rand_rise", rand_rise, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_reject_cnt", reject_cnt, 0);
        reset = 1'b0;
        bit_q.delete();
        sb_q.delete();
        rej_model = 0;
    endtask

    task automatic push_exp(input logic [3:0] data, input int nrej, input int lat, input int rises);
        exp_t e;
        rej_model = (rej_model + nrej > 255) ? 255 : rej_model + nrej;
        e.data = data;
        e.rej = rej_model;
        e.lat = lat;
        e.rises = rises;
        sb_q.push_back(e);
    endtask

    task automatic launch();
        r0 = rise_cnt;
        start = 1'b1;
        step();
        t0 = cyc;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_and_score(input int budget);
        exp_t e;
        int   n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("reject_cnt", reject_cnt, e.rej);
            chk("latency", cyc - t0, e.lat);
            chk("rise_pulses", rise_cnt - r0, e.rises);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("idle_after_xfer", busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = v.nbits - 1; i >= 0; i--) bit_q.push_back(v.bits[i]);
        push_exp(v.data, v.nrej, v.lat, v.nbits);
        launch();
        wait_and_score(v.lat + 20);
        handshake();
    endtask

    initial begin
        int rs;
        int n;
        logic [3:0] held;

        vecs[0] = '{16'h0005, 4,  4'd5, 0, 17};
        vecs[1] = '{16'h00F3, 8,  4'd3, 1, 34};
        vecs[2] = '{16'h0019, 8,  4'd9, 1, 34};
        vecs[3] = '{16'h0002, 4,  4'd2, 0, 17};
        vecs[4] = '{16'h0A08, 12, 4'd8, 2, 51};
        vecs[5] = '{16'h0A17, 12, 4'd7, 2, 51};
        vecs[6] = '{16'h0006, 4,  4'd6, 0, 17};

        do_reset();

`ifndef RANDOM_WORD_LFSR_MIX_EN
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Consumer stalls; start pulses while busy must not be queued
        bit_q.push_back(1'b0); bit_q.push_back(1'b1);
        bit_q.push_back(1'b0); bit_q.push_back(1'b0);
        push_exp(4'd4, 0, WORD_T, 4);
        launch();
        wait_and_score(WORD_T + 20);
        held = 4'd4;
        rs = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3) ? 1'b1 : 1'b0;
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held);
        end
        start = 1'b0;
        chk("stall_no_rise", rise_cnt - rs, 0);
        // Start coincident with the transfer is ignored
        out_ready = 1'b1;
        start = 1'b1;
        step();
        out_ready = 1'b0;
        start = 1'b0;
        chk("xfer_valid_drop", out_valid, 0);
        chk("xfer_idle", busy, 0);
        repeat (6) step();
        chk("xfer_still_idle", busy, 0);
        chk("xfer_no_rise", rise_cnt - rs, 0);

        // Reject counter saturates at 255
        for (int i = 0; i < 260 * 4; i++) bit_q.push_back(1'b1);
        bit_q.push_back(1'b0); bit_q.push_back(1'b1);
        bit_q.push_back(1'b0); bit_q.push_back(1'b1);
        push_exp(4'd5, 260, 261 * WORD_T, 261 * 4);
        launch();
        wait_and_score(261 * WORD_T + 50);
        handshake();

        // Reset asserted during the third WAIT discards the partial word
        bit_q.push_back(1'b1); bit_q.push_back(1'b1);
        bit_q.push_back(1'b0); bit_q.push_back(1'b1);
        launch();
        n = 0;
        while (rise_cnt - r0 < 3 && n < 40) begin
            step();
            n++;
        end
        chk("third_rise_seen", rise_cnt - r0, 3);
        reset = 1'b1;
        step();
        chk("midrst_rand_rise", rand_rise, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_reject_cnt", reject_cnt, 0);
        reset = 1'b0;
        bit_q.delete();
        sb_q.delete();
        rej_model = 0;
        step();
        run_vec('{16'h0007, 4, 4'd7, 0, 17});
`else
        // LFSR mixing with the raw source held at 0
        cap_q.delete();
        launch();
        n = 0;
        while (out_valid !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk("lfsr_valid_seen", out_valid, 1);
        n = cap_q.size();
        chk("lfsr_cap_multiple", n % 4, 0);
        chk("lfsr_rises", rise_cnt - r0, n);
        if (n >= 4) begin
            chk("lfsr_data", out_data, {cap_q[n-4], cap_q[n-3], cap_q[n-2], cap_q[n-1]});
            chk("lfsr_rejects", reject_cnt, (n / 4 - 1 > 255) ? 255 : n / 4 - 1);
            chk("lfsr_latency", cyc - t0, (n / 4) * WORD_T);
        end
        handshake();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
